// File: rtl/fifo_write_arbiter.sv
// fifo_write_arbiter
// Round-robin arbiter that shares the single write port of the event FIFO
// between NUM_CHANNELS word builders. A winning channel's word is
// registered, written with a one-cycle active-low strobe, acknowledged
// with a matching one-cycle ack pulse, and then one idle SETTLE cycle
// gives the FIFO time to update its full flag before the next arbitration.
//
// Ports:
//   clk, reset    core clock, synchronous active-high reset
//   ch_req        per-channel request (held with stable data until acked)
//   ch_data       flattened channel words, channel k at [k*FIFO_WIDTH +: FIFO_WIDTH]
//   ch_mask       per-channel enable; masked requests are ignored
//   ch_ack        one-hot, one-cycle pulse coinciding with the write strobe
//   fifo_full     FIFO full flag, sampled only while IDLE
//   fifo_data_in  registered word to the FIFO
//   fifo_write_n  active-low write strobe, one cycle per word
//   grant_id      index of the channel currently or last granted
//   busy          high whenever the FSM is not IDLE
//   stall_count   saturating count of IDLE cycles blocked by fifo_full
module fifo_write_arbiter #(
  parameter int NUM_CHANNELS = 8,
  parameter int FIFO_WIDTH   = 63,
  parameter int CH_BITS      = $clog2(NUM_CHANNELS)
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic [NUM_CHANNELS-1:0]            ch_req,
  input  logic [NUM_CHANNELS*FIFO_WIDTH-1:0] ch_data,
  input  logic [NUM_CHANNELS-1:0]            ch_mask,
  output logic [NUM_CHANNELS-1:0]            ch_ack,
  input  logic                               fifo_full,
  output logic [FIFO_WIDTH-1:0]              fifo_data_in,
  output logic                               fifo_write_n,
  output logic [CH_BITS-1:0]                 grant_id,
  output logic                               busy,
  output logic [15:0]                        stall_count
);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] WRITE  = 2'd1;
  localparam logic [1:0] SETTLE = 2'd2;

  localparam logic [CH_BITS-1:0] LAST_CH = CH_BITS'(NUM_CHANNELS - 1);

  logic [1:0]              state_q, state_d;
  logic                    write_n_q, write_n_d;
  logic [NUM_CHANNELS-1:0] ack_q, ack_d;
  logic [FIFO_WIDTH-1:0]   data_q, data_d;
  logic [CH_BITS-1:0]      grant_q, grant_d;
  logic [CH_BITS-1:0]      last_grant_q, last_grant_d;
  logic                    busy_q, busy_d;
  logic [15:0]             stall_q, stall_d;

  logic [NUM_CHANNELS-1:0] elig;
  logic                    found;
  logic [CH_BITS-1:0]      winner;

  // Unflatten the channel words so the winner can be selected by index.
  logic [FIFO_WIDTH-1:0] ch_word [NUM_CHANNELS];

  genvar gi;
  generate
    for (gi = 0; gi < NUM_CHANNELS; gi++) begin : g_unpack
      assign ch_word[gi] = ch_data[gi*FIFO_WIDTH +: FIFO_WIDTH];
    end
  endgenerate

  assign elig = ch_req & ch_mask;

  // Rotating priority without modulo arithmetic: the first pass looks only
  // above last_grant; if nothing is found there, the second pass takes the
  // lowest eligible channel, which completes the wrap-around search.
  always_comb begin
    found  = 1'b0;
    winner = '0;
    for (int j = 0; j < NUM_CHANNELS; j++) begin
      if (!found && elig[j] && (CH_BITS'(j) > last_grant_q)) begin
        found  = 1'b1;
        winner = CH_BITS'(j);
      end
    end
    for (int j = 0; j < NUM_CHANNELS; j++) begin
      if (!found && elig[j]) begin
        found  = 1'b1;
        winner = CH_BITS'(j);
      end
    end
  end

  always_comb begin
    state_d      = state_q;
    write_n_d    = 1'b1;
    ack_d        = '0;
    data_d       = data_q;
    grant_d      = grant_q;
    last_grant_d = last_grant_q;
    stall_d      = stall_q;
    case (state_q)
      IDLE: begin
        if (found) begin
          if (!fifo_full) begin
            // Strobe and ack are loaded here so they are both asserted
            // for exactly the WRITE cycle.
            state_d       = WRITE;
            grant_d       = winner;
            last_grant_d  = winner;
            data_d        = ch_word[winner];
            write_n_d     = 1'b0;
            ack_d[winner] = 1'b1;
          end else if (stall_q != 16'hFFFF) begin
            stall_d = stall_q + 16'd1;
          end
        end
      end
      // The grant is committed: requester or mask changes are ignored here.
      WRITE:   state_d = SETTLE;
      SETTLE:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      write_n_q    <= 1'b1;
      ack_q        <= '0;
      data_q       <= '0;
      grant_q      <= '0;
      last_grant_q <= LAST_CH;
      busy_q       <= 1'b0;
      stall_q      <= '0;
    end else begin
      state_q      <= state_d;
      write_n_q    <= write_n_d;
      ack_q        <= ack_d;
      data_q       <= data_d;
      grant_q      <= grant_d;
      last_grant_q <= last_grant_d;
      busy_q       <= busy_d;
      stall_q      <= stall_d;
    end
  end

  assign ch_ack       = ack_q;
  assign fifo_data_in = data_q;
  assign fifo_write_n = write_n_q;
  assign grant_id     = grant_q;
  assign busy         = busy_q;
  assign stall_count  = stall_q;

endmodule

// File: tb/tb_fifo_write_arbiter.sv
module tb_fifo_write_arbiter;

  localparam int N = 8;
  localparam int W = 63;

  localparam logic [W-1:0] D0 = 63'h0_0000_1234;
  localparam logic [W-1:0] D2 = 63'h2_0000_1234;
  localparam logic [W-1:0] D3 = 63'h3_0000_1234;
  localparam logic [W-1:0] D6 = 63'h6_0000_1234;

  logic           clk = 1'b0;
  logic           reset;
  logic [N-1:0]   ch_req;
  logic [N*W-1:0] ch_data;
  logic [N-1:0]   ch_mask;
  logic [N-1:0]   ch_ack;
  logic           fifo_full;
  logic [W-1:0]   fifo_data_in;
  logic           fifo_write_n;
  logic [2:0]     grant_id;
  logic           busy;
  logic [15:0]    stall_count;

  int n_tests = 0;
  int n_fail  = 0;

  fifo_write_arbiter #(.NUM_CHANNELS(N), .FIFO_WIDTH(W)) dut (
    .clk          (clk),
    .reset        (reset),
    .ch_req       (ch_req),
    .ch_data      (ch_data),
    .ch_mask      (ch_mask),
    .ch_ack       (ch_ack),
    .fifo_full    (fifo_full),
    .fifo_data_in (fifo_data_in),
    .fifo_write_n (fifo_write_n),
    .grant_id     (grant_id),
    .busy         (busy),
    .stall_count  (stall_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0]   req;
    logic [7:0]   mask;
    logic         full;
    logic         exp_wn;
    logic [7:0]   exp_ack;
    logic [2:0]   exp_gid;
    logic         exp_busy;
    logic [W-1:0] exp_data;
    logic [15:0]  exp_stall;
    string        name;
  } vec_t;

  vec_t vecs [18];

  // Channel k carries 0x1234 with k in bits [34:32].
  function automatic logic [W-1:0] word_of(input int k);
    return 63'h1234 + (63'(k) << 32);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_all(input string name, input logic wn, input logic [7:0] ack,
                           input logic [2:0] gid, input logic bsy,
                           input logic [W-1:0] data, input logic [15:0] stall);
    n_tests++;
    if ({fifo_write_n, ch_ack, grant_id, busy, fifo_data_in, stall_count} !==
        {wn, ack, gid, bsy, data, stall}) begin
      n_fail++;
      $display("[TB] FAIL %s: got wn=%b ack=%h gid=%0d busy=%b data=%h stall=%h; want wn=%b ack=%h gid=%0d busy=%b data=%h stall=%h",
               name, fifo_write_n, ch_ack, grant_id, busy, fifo_data_in, stall_count,
               wn, ack, gid, bsy, data, stall);
    end else begin
      $display("[TB] ok %s: wn=%b ack=%h gid=%0d busy=%b stall=%0d",
               name, fifo_write_n, ch_ack, grant_id, busy, stall_count);
    end
  endtask

  task automatic do_reset();
    reset     = 1'b1;
    ch_req    = '0;
    ch_mask   = 8'hFF;
    fifo_full = 1'b0;
    tick();
    tick();
    reset = 1'b0;
  endtask

  initial begin
    for (int k = 0; k < N; k++) ch_data[k*W +: W] = word_of(k);

    //                 req    mask   full  wn    ack    gid   busy  data stall  name
    vecs[0]  = '{8'h01, 8'hFF, 1'b0, 1'b0, 8'h01, 3'd0, 1'b1, D0, 16'd0, "t1 grant ch0"};
    vecs[1]  = '{8'h00, 8'hFF, 1'b0, 1'b1, 8'h00, 3'd0, 1'b1, D0, 16'd0, "t1 settle"};
    vecs[2]  = '{8'h00, 8'hFF, 1'b0, 1'b1, 8'h00, 3'd0, 1'b0, D0, 16'd0, "t1 back to idle"};
    vecs[3]  = '{8'h00, 8'hFF, 1'b0, 1'b1, 8'h00, 3'd0, 1'b0, D0, 16'd0, "t1 idle no req"};
    vecs[4]  = '{8'h0C, 8'h08, 1'b0, 1'b0, 8'h08, 3'd3, 1'b1, D3, 16'd0, "t4 masked pick ch3"};
    vecs[5]  = '{8'h04, 8'h08, 1'b0, 1'b1, 8'h00, 3'd3, 1'b1, D3, 16'd0, "t4 settle"};
    vecs[6]  = '{8'h04, 8'h08, 1'b0, 1'b1, 8'h00, 3'd3, 1'b0, D3, 16'd0, "t4 idle"};
    vecs[7]  = '{8'h04, 8'h08, 1'b0, 1'b1, 8'h00, 3'd3, 1'b0, D3, 16'd0, "t4 ch2 stays masked"};
    vecs[8]  = '{8'h04, 8'hFF, 1'b0, 1'b0, 8'h04, 3'd2, 1'b1, D2, 16'd0, "t4 unmasked ch2 wraps"};
    vecs[9]  = '{8'h00, 8'h00, 1'b0, 1'b1, 8'h00, 3'd2, 1'b1, D2, 16'd0, "t6 drop in write settles"};
    vecs[10] = '{8'h00, 8'hFF, 1'b0, 1'b1, 8'h00, 3'd2, 1'b0, D2, 16'd0, "t6 idle"};
    vecs[11] = '{8'h00, 8'hFF, 1'b0, 1'b1, 8'h00, 3'd2, 1'b0, D2, 16'd0, "t6 no regrant"};
    vecs[12] = '{8'h40, 8'hFF, 1'b0, 1'b0, 8'h40, 3'd6, 1'b1, D6, 16'd0, "spacing grant ch6"};
    vecs[13] = '{8'h41, 8'hFF, 1'b0, 1'b1, 8'h00, 3'd6, 1'b1, D6, 16'd0, "spacing no grant in write"};
    vecs[14] = '{8'h01, 8'hFF, 1'b0, 1'b1, 8'h00, 3'd6, 1'b0, D6, 16'd0, "spacing no grant in settle"};
    vecs[15] = '{8'h01, 8'hFF, 1'b0, 1'b0, 8'h01, 3'd0, 1'b1, D0, 16'd0, "spacing grant ch0 3 later"};
    vecs[16] = '{8'h00, 8'hFF, 1'b0, 1'b1, 8'h00, 3'd0, 1'b1, D0, 16'd0, "spacing settle"};
    vecs[17] = '{8'h00, 8'hFF, 1'b0, 1'b1, 8'h00, 3'd0, 1'b0, D0, 16'd0, "spacing idle"};

    // Reset state.
    do_reset();
    check_all("reset state", 1'b1, 8'h00, 3'd0, 1'b0, '0, 16'd0);

    // Table-driven single-cycle vectors.
    for (int v = 0; v < 18; v++) begin
      ch_req    = vecs[v].req;
      ch_mask   = vecs[v].mask;
      fifo_full = vecs[v].full;
      tick();
      check_all(vecs[v].name, vecs[v].exp_wn, vecs[v].exp_ack, vecs[v].exp_gid,
                vecs[v].exp_busy, vecs[v].exp_data, vecs[v].exp_stall);
    end

    // All channels requesting: grants 0..7,0 exactly 3 cycles apart.
    do_reset();
    ch_req = 8'hFF;
    for (int c = 1; c <= 27; c++) begin
      int g;
      g = ((c - 1) / 3) % N;
      tick();
      if (c % 3 == 1)
        check_all($sformatf("t2 cycle %0d strobe ch%0d", c, g), 1'b0, 8'(1 << g),
                  3'(g), 1'b1, word_of(g), 16'd0);
      else
        check_all($sformatf("t2 cycle %0d quiet", c), 1'b1, 8'h00, 3'(g),
                  (c % 3 != 0), word_of(g), 16'd0);
    end

    // Backpressure: 10 full cycles, then ch0 then ch2; full outside IDLE is ignored.
    do_reset();
    ch_req    = 8'h05;
    fifo_full = 1'b1;
    repeat (10) tick();
    check_all("t3 stalled 10", 1'b1, 8'h00, 3'd0, 1'b0, '0, 16'd10);
    fifo_full = 1'b0;
    tick();
    check_all("t3 grant ch0 after full", 1'b0, 8'h01, 3'd0, 1'b1, D0, 16'd10);
    fifo_full = 1'b1;
    tick();
    check_all("t3 full in write ignored", 1'b1, 8'h00, 3'd0, 1'b1, D0, 16'd10);
    tick();
    check_all("t3 full in settle ignored", 1'b1, 8'h00, 3'd0, 1'b0, D0, 16'd10);
    fifo_full = 1'b0;
    tick();
    check_all("t3 grant ch2", 1'b0, 8'h04, 3'd2, 1'b1, D2, 16'd10);

    // Stall counter saturation.
    do_reset();
    ch_req    = 8'h01;
    fifo_full = 1'b1;
    repeat (65534) tick();
    check_all("t3 stall one below max", 1'b1, 8'h00, 3'd0, 1'b0, '0, 16'hFFFE);
    tick();
    check_all("t3 stall reaches max", 1'b1, 8'h00, 3'd0, 1'b0, '0, 16'hFFFF);
    repeat (5) tick();
    check_all("t3 stall saturated", 1'b1, 8'h00, 3'd0, 1'b0, '0, 16'hFFFF);
    fifo_full = 1'b0;
    tick();
    check_all("t3 grant after saturation", 1'b0, 8'h01, 3'd0, 1'b1, D0, 16'hFFFF);

    // Reset during WRITE; priority must restart from channel 0.
    do_reset();
    ch_req = 8'h02;
    tick();
    check_all("t5 grant ch1", 1'b0, 8'h02, 3'd1, 1'b1, word_of(1), 16'd0);
    ch_req = 8'h00;
    tick();
    tick();
    check_all("t5 idle before regrant", 1'b1, 8'h00, 3'd1, 1'b0, word_of(1), 16'd0);
    ch_req = 8'h02;
    tick();
    check_all("t5 second write ch1", 1'b0, 8'h02, 3'd1, 1'b1, word_of(1), 16'd0);
    reset = 1'b1;
    tick();
    check_all("t5 reset in write", 1'b1, 8'h00, 3'd0, 1'b0, '0, 16'd0);
    reset  = 1'b0;
    ch_req = 8'h06;
    tick();
    check_all("t5 priority restarts ch1", 1'b0, 8'h02, 3'd1, 1'b1, word_of(1), 16'd0);
    ch_req = 8'h02;
    tick();
    tick();
    tick();
    check_all("t5 req 02 granted ch1", 1'b0, 8'h02, 3'd1, 1'b1, word_of(1), 16'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
